// File: rtl/cnn_weight_loader.sv
// CNN weight loader: packs a signed byte stream into feature, bias and fully-connected
// weight words, strobes each finished word into its memory, then pulses the CNN start.
module cnn_weight_loader #(
    parameter int DATA_WIDTH       = 8,
    parameter int NUM_FEATURES     = 3,
    parameter int KERNEL_SIZE      = 4,
    parameter int FLATTENED_LENGTH = 432
) (
    input  logic                                                        clk,
    input  logic                                                        rst_loader,
    input  logic                                                        start,
    input  logic signed [DATA_WIDTH-1:0]                                in_data,
    input  logic                                                        in_valid,
    output logic                                                        in_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]               feature_weights_output,
    output logic [$clog2(NUM_FEATURES)-1:0]                             feature_writeAddr,
    output logic                                                        feature_WrEn,
    output logic [4*DATA_WIDTH-1:0]                                     bias_weights_output,
    output logic                                                        bias_WrEn,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]               fullyconnected_weights_output,
    output logic [$clog2(FLATTENED_LENGTH/(KERNEL_SIZE*KERNEL_SIZE))-1:0] fullyconnected_writeAddr,
    output logic                                                        fullyconnected_WrEn,
    output logic                                                        convolution_enable,
    output logic                                                        busy,
    output logic                                                        done
);
    localparam int WORD_BYTES = KERNEL_SIZE * KERNEL_SIZE;
    localparam int WORD_W     = WORD_BYTES * DATA_WIDTH;
    localparam int BIAS_BYTES = 4;
    localparam int BIAS_W     = BIAS_BYTES * DATA_WIDTH;
    localparam int FC_WORDS   = FLATTENED_LENGTH / WORD_BYTES;
    localparam int FEAT_AW    = $clog2(NUM_FEATURES);
    localparam int FC_AW      = $clog2(FC_WORDS);
    localparam int CNT_W      = $clog2(WORD_BYTES);

    localparam logic [CNT_W-1:0]   LAST_WORD_BYTE = CNT_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0]   LAST_BIAS_BYTE = CNT_W'(BIAS_BYTES - 1);
    localparam logic [FEAT_AW-1:0] LAST_FEAT_SLOT = FEAT_AW'(NUM_FEATURES - 1);
    localparam logic [FC_AW-1:0]   LAST_FC_ADDR   = FC_AW'(FC_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FEAT,
        WR_FEAT,
        LOAD_BIAS,
        WR_BIAS,
        LOAD_FC,
        WR_FC,
        START_CNN
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] byte_cnt;
    logic             accept;
    logic             word_done;

    // Byte handshake: a byte transfers on a rising edge where in_valid && in_ready are both
    // high; in_ready is a pure decode of the state and never depends on in_valid.
    assign accept    = in_valid && in_ready;
    assign word_done = accept && ((state == LOAD_BIAS) ? (byte_cnt == LAST_BIAS_BYTE)
                                                       : (byte_cnt == LAST_WORD_BYTE));

    always_ff @(posedge clk or negedge rst_loader) begin
        if (!rst_loader) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state          = state;
        in_ready            = 1'b0;
        busy                = 1'b1;
        feature_WrEn        = 1'b1;
        bias_WrEn           = 1'b1;
        fullyconnected_WrEn = 1'b1;
        convolution_enable  = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = LOAD_FEAT;
            end
            LOAD_FEAT: begin
                in_ready = 1'b1;
                if (word_done) next_state = WR_FEAT;
            end
            WR_FEAT: begin
                feature_WrEn = 1'b0;
                next_state   = (feature_writeAddr == LAST_FEAT_SLOT) ? LOAD_BIAS : LOAD_FEAT;
            end
            LOAD_BIAS: begin
                in_ready = 1'b1;
                if (word_done) next_state = WR_BIAS;
            end
            WR_BIAS: begin
                bias_WrEn  = 1'b0;
                next_state = LOAD_FC;
            end
            LOAD_FC: begin
                in_ready = 1'b1;
                if (word_done) next_state = WR_FC;
            end
            WR_FC: begin
                fullyconnected_WrEn = 1'b0;
                next_state = (fullyconnected_writeAddr == LAST_FC_ADDR) ? START_CNN : LOAD_FC;
            end
            START_CNN: begin
                convolution_enable = 1'b0;
                next_state         = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The packing registers double as the data outputs; they move only on accepted bytes,
    // so each word is already stable during its write-strobe cycle.
    always_ff @(posedge clk or negedge rst_loader) begin
        if (!rst_loader) begin
            byte_cnt                      <= '0;
            feature_weights_output        <= '0;
            feature_writeAddr             <= '0;
            bias_weights_output           <= '0;
            fullyconnected_weights_output <= '0;
            fullyconnected_writeAddr      <= '0;
            done                          <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                byte_cnt                 <= '0;
                feature_writeAddr        <= '0;
                fullyconnected_writeAddr <= '0;
                done                     <= 1'b0;
            end
            if (accept) begin
                byte_cnt <= word_done ? '0 : byte_cnt + CNT_W'(1);
                case (state)
                    LOAD_FEAT: feature_weights_output <=
                        {feature_weights_output[WORD_W-DATA_WIDTH-1:0], in_data};
                    LOAD_BIAS: bias_weights_output <=
                        {bias_weights_output[BIAS_W-DATA_WIDTH-1:0], in_data};
                    LOAD_FC: fullyconnected_weights_output <=
                        {fullyconnected_weights_output[WORD_W-DATA_WIDTH-1:0], in_data};
                    default: ;
                endcase
            end
            if (state == WR_FEAT && feature_writeAddr != LAST_FEAT_SLOT) begin
                feature_writeAddr <= feature_writeAddr + FEAT_AW'(1);
            end
            if (state == WR_FC && fullyconnected_writeAddr != LAST_FC_ADDR) begin
                fullyconnected_writeAddr <= fullyconnected_writeAddr + FC_AW'(1);
            end
            if (state == START_CNN) begin
                done <= 1'b1;
            end
        end
    end

    // At most one memory write strobe may be active in any cycle.
    a_one_strobe: assert property (@(posedge clk) disable iff (!rst_loader)
        $countones({~feature_WrEn, ~bias_WrEn, ~fullyconnected_WrEn}) <= 1);

    a_ready_only_loading: assert property (@(posedge clk) disable iff (!rst_loader)
        in_ready |-> busy);

endmodule

// File: tb/tb_cnn_weight_loader.sv
// Bench for cnn_weight_loader: a byte-stream model builds the expected write sequence,
// a negedge monitor checks every strobe against it, directed runs cover the scenarios.
module tb_cnn_weight_loader;
    localparam int N_BYTES = 484;

    logic               clk = 1'b0;
    logic               rst_loader;
    logic               start;
    logic signed [7:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       feature_weights_output;
    logic [1:0]         feature_writeAddr;
    logic               feature_WrEn;
    logic [31:0]        bias_weights_output;
    logic               bias_WrEn;
    logic [127:0]       fullyconnected_weights_output;
    logic [4:0]         fullyconnected_writeAddr;
    logic               fullyconnected_WrEn;
    logic               convolution_enable;
    logic               busy;
    logic               done;

    cnn_weight_loader dut (
        .clk                           (clk),
        .rst_loader                    (rst_loader),
        .start                         (start),
        .in_data                       (in_data),
        .in_valid                      (in_valid),
        .in_ready                      (in_ready),
        .feature_weights_output        (feature_weights_output),
        .feature_writeAddr             (feature_writeAddr),
        .feature_WrEn                  (feature_WrEn),
        .bias_weights_output           (bias_weights_output),
        .bias_WrEn                     (bias_WrEn),
        .fullyconnected_weights_output (fullyconnected_weights_output),
        .fullyconnected_writeAddr      (fullyconnected_writeAddr),
        .fullyconnected_WrEn           (fullyconnected_WrEn),
        .convolution_enable            (convolution_enable),
        .busy                          (busy),
        .done                          (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   stream [N_BYTES];
    logic [127:0] exp_q [$];
    int           exp_kind_q [$];
    int           exp_addr_q [$];
    int           exp_bytes_q [$];

    int           consumed = 0;
    int           n_wr = 0;
    int           n_fc = 0;
    int           n_cnn = 0;
    int           first_load_cyc = 0;
    int           last_latency = 0;
    logic [3:0]   prev_lows = '0;
    logic         prev_busy = 1'b0;

    logic [127:0] cap_feat [3];
    logic [31:0]  cap_bias;
    logic [127:0] cap_fc [27];
    logic [127:0] ref_feat [3];
    logic [31:0]  ref_bias;
    logic [127:0] ref_fc [27];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic init_stream();
        int f0 [16] = '{-53, 43, 7, -12, 99, -100, 1, 0, 127, -128, 64, -1, 33, -77, 5, 26};
        int b [4]   = '{10, 0, 0, -8};
        for (int i = 0; i < 16; i++) stream[i] = 8'(f0[i]);
        for (int i = 16; i < 48; i++) stream[i] = 8'((i * 29 + 3) % 256);
        for (int i = 0; i < 4; i++) stream[48 + i] = 8'(b[i]);
        for (int n = 0; n < 432; n++) stream[52 + n] = 8'(n % 256);
    endtask

    // Element 0 of a word is the first byte streamed and sits in the top byte.
    function automatic logic [127:0] pack16(input int base);
        logic [127:0] w = '0;
        for (int i = 0; i < 16; i++) w[127 - 8 * i -: 8] = stream[base + i];
        return w;
    endfunction

    function automatic logic [31:0] bias_word();
        return {stream[48], stream[49], stream[50], stream[51]};
    endfunction

    // kind: 0 feature, 1 bias, 2 fully-connected, 3 CNN start pulse
    task automatic push_exp(input int kind, input int addr, input logic [127:0] data, input int bytes);
        exp_kind_q.push_back(kind);
        exp_addr_q.push_back(addr);
        exp_q.push_back(data);
        exp_bytes_q.push_back(bytes);
    endtask

    task automatic build_expected();
        for (int f = 0; f < 3; f++) push_exp(0, f, pack16(16 * f), 16 * (f + 1));
        push_exp(1, 0, {96'b0, bias_word()}, 52);
        for (int j = 0; j < 27; j++) push_exp(2, j, pack16(52 + 16 * j), 52 + 16 * (j + 1));
        push_exp(3, 0, '0, N_BYTES);
    endtask

    // ---------------- monitor / compare ----------------
    always @(negedge clk) begin : monitor
        logic [3:0]   lows;
        int           kind;
        int           ek;
        int           ea;
        int           eb;
        logic [127:0] ed;
        lows = {~feature_WrEn, ~bias_WrEn, ~fullyconnected_WrEn, ~convolution_enable};
        if (!rst_loader) begin
            check("strobe_in_reset", 128'(lows), '0);
            exp_q.delete();
            exp_kind_q.delete();
            exp_addr_q.delete();
            exp_bytes_q.delete();
            prev_lows = '0;
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                consumed       = 0;
                first_load_cyc = cyc;
                for (int i = 0; i < 3; i++) cap_feat[i] = '0;
                for (int i = 0; i < 27; i++) cap_fc[i] = '0;
                cap_bias = '0;
            end
            if (!busy && in_valid) check("idle_ready", 128'(in_ready), '0);
            if (in_valid && in_ready) consumed++;
            if (lows != 0) begin
                check("strobe_count", 128'($countones(lows)), 128'(1));
                check("strobe_width", 128'(prev_lows & lows), '0);
                kind = lows[3] ? 0 : (lows[2] ? 1 : (lows[1] ? 2 : 3));
                case (kind)
                    0: begin
                        n_wr++;
                        if (feature_writeAddr < 3) cap_feat[feature_writeAddr] = feature_weights_output;
                    end
                    1: begin
                        n_wr++;
                        cap_bias = bias_weights_output;
                    end
                    2: begin
                        n_wr++;
                        n_fc++;
                        if (fullyconnected_writeAddr < 27)
                            cap_fc[fullyconnected_writeAddr] = fullyconnected_weights_output;
                    end
                    default: begin
                        n_cnn++;
                        last_latency = cyc - first_load_cyc + 1;
                    end
                endcase
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 128'(lows), '0);
                end else begin
                    ed = exp_q.pop_front();
                    ek = exp_kind_q.pop_front();
                    ea = exp_addr_q.pop_front();
                    eb = exp_bytes_q.pop_front();
                    check("strobe_kind", 128'(kind), 128'(ek));
                    check("bytes_before_strobe", 128'(consumed), 128'(eb));
                    case (kind)
                        0: begin
                            check("feat_addr", 128'(feature_writeAddr), 128'(ea));
                            check("feat_data", feature_weights_output, ed);
                        end
                        1: check("bias_data", {96'b0, bias_weights_output}, ed);
                        2: begin
                            check("fc_addr", 128'(fullyconnected_writeAddr), 128'(ea));
                            check("fc_data", fullyconnected_weights_output, ed);
                        end
                        default: ;
                    endcase
                end
            end
            prev_lows = lows;
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_stream(input int gap_pct, input int nbytes, input bit start_noise);
        int idx   = 0;
        int guard = 0;
        bit take;
        while (idx < nbytes && guard < 20000) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom_range(0, 255));
            end else begin
                in_valid = 1'b1;
                in_data  = stream[idx];
            end
            if (start_noise) start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            take = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (take) idx++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < nbytes) check("stream_timeout", 128'(idx), 128'(nbytes));
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        @(negedge clk);
        while (!done && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_done"}, 128'(done), 128'(1));
        check({tag, "_busy"}, 128'(busy), '0);
        check({tag, "_queue_drained"}, 128'(exp_q.size()), '0);
    endtask

    task automatic idle_noise(input int n);
        int snap = consumed;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_no_consume", 128'(consumed), 128'(snap));
        check("idle_busy", 128'(busy), '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"},
              128'({feature_WrEn, bias_WrEn, fullyconnected_WrEn, convolution_enable}), 128'(4'hF));
        check({tag, "_ready_busy_done"}, 128'({in_ready, busy, done}), '0);
        check({tag, "_feat_word"}, feature_weights_output, '0);
        check({tag, "_bias_word"}, {96'b0, bias_weights_output}, '0);
        check({tag, "_fc_word"}, fullyconnected_weights_output, '0);
        check({tag, "_addrs"}, 128'({feature_writeAddr, fullyconnected_writeAddr}), '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base_wr;
        int base_cnn;
        int base_fc;
        init_stream();
        rst_loader = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;

        // Hand-computed words pin the model.
        check("model_feat0", pack16(0), 128'hCB2B07F4639C01007F8040FF21B3051A);
        check("model_bias", {96'b0, bias_word()}, 128'h0A0000F8);
        check("model_fc0", pack16(52), 128'h000102030405060708090A0B0C0D0E0F);
        check("model_fc26", pack16(52 + 16 * 26), 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

        #23;
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_loader = 1'b1;

        idle_noise(6);

        // Run A: full load with in_valid held high.
        build_expected();
        base_wr  = n_wr;
        base_cnn = n_cnn;
        do_start();
        run_stream(0, N_BYTES, 1'b0);
        wait_done("run_a");
        check("run_a_latency", 128'(last_latency), 128'(516));
        check("run_a_writes", 128'(n_wr - base_wr), 128'(31));
        check("run_a_cnn_pulses", 128'(n_cnn - base_cnn), 128'(1));
        check("run_a_feat0_lit", cap_feat[0], 128'hCB2B07F4639C01007F8040FF21B3051A);
        check("run_a_bias_lit", {96'b0, cap_bias}, 128'h0A0000F8);
        check("run_a_fc0_lit", cap_fc[0], 128'h000102030405060708090A0B0C0D0E0F);
        check("run_a_fc26_lit", cap_fc[26], 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        for (int i = 0; i < 3; i++) ref_feat[i] = cap_feat[i];
        for (int i = 0; i < 27; i++) ref_fc[i] = cap_fc[i];
        ref_bias = cap_bias;

        idle_noise(5);
        check("done_held_idle", 128'(done), 128'(1));

        // Run B: random valid gaps and start pulses while busy.
        build_expected();
        base_wr  = n_wr;
        base_cnn = n_cnn;
        do_start();
        check("start_clears_done", 128'({busy, done}), 128'(2'b10));
        run_stream(40, N_BYTES, 1'b1);
        wait_done("run_b");
        check("run_b_writes", 128'(n_wr - base_wr), 128'(31));
        check("run_b_cnn_pulses", 128'(n_cnn - base_cnn), 128'(1));
        for (int i = 0; i < 3; i++) check("run_b_feat_same", cap_feat[i], ref_feat[i]);
        check("run_b_bias_same", {96'b0, cap_bias}, {96'b0, ref_bias});
        for (int i = 0; i < 27; i++) check("run_b_fc_same", cap_fc[i], ref_fc[i]);

        // Run C: reset asserted after FC word 10 was written.
        build_expected();
        base_fc = n_fc;
        do_start();
        run_stream(30, 52 + 16 * 11, 1'b0);
        repeat (3) @(negedge clk);
        check("fc_before_reset", 128'(n_fc - base_fc), 128'(11));
        @(posedge clk);
        #1 rst_loader = 1'b0;
        #1 check_reset_outputs("mid_fc");
        repeat (3) @(posedge clk);
        #1 rst_loader = 1'b1;

        // Run D: restart reloads from byte 0 and completes normally.
        build_expected();
        base_wr  = n_wr;
        base_cnn = n_cnn;
        do_start();
        run_stream(0, N_BYTES, 1'b0);
        wait_done("run_d");
        check("run_d_latency", 128'(last_latency), 128'(516));
        check("run_d_writes", 128'(n_wr - base_wr), 128'(31));
        check("run_d_cnn_pulses", 128'(n_cnn - base_cnn), 128'(1));
        check("run_d_feat0_lit", cap_feat[0], 128'hCB2B07F4639C01007F8040FF21B3051A);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnn_weight_loader.md
CNN_WEIGHT_LOADER -- requirements
Module: cnn_weight_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of one signed weight byte.
REQ-002 SHALL have parameter NUM_FEATURES, default 3, meaning the number of feature maps loaded.
REQ-003 SHALL have parameter KERNEL_SIZE, default 4, meaning the kernel edge; each feature word holds KERNEL_SIZE*KERNEL_SIZE = 16 bytes.
REQ-004 SHALL have parameter FLATTENED_LENGTH, default 432, meaning the number of FC weights; these are written as 27 words of 16 bytes.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_loader, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: a high level sampled in IDLE begins a load sequence.
REQ-008 SHALL have port in_data, input, 8 bits, signed: a weight byte from the stream.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts a byte; transfer occurs when in_valid and in_ready are both high.
REQ-011 SHALL have port feature_weights_output, output, 128 bits: the packed feature word, with element 0 in bits [127:120].
REQ-012 SHALL have port feature_writeAddr, output, 2 bits: the feature slot 0..2.
REQ-013 SHALL have port feature_WrEn, output, 1 bit: feature write strobe, active-low.
REQ-014 SHALL have port bias_weights_output, output, 32 bits: the packed biases, with element 0 in bits [31:24].
REQ-015 SHALL have port bias_WrEn, output, 1 bit: bias write strobe, active-low.
REQ-016 SHALL have port fullyconnected_weights_output, output, 128 bits: the packed FC word, with element 0 in the MSBs.
REQ-017 SHALL have port fullyconnected_writeAddr, output, 5 bits: the FC word address 0..26.
REQ-018 SHALL have port fullyconnected_WrEn, output, 1 bit: FC write strobe, active-low.
REQ-019 SHALL have port convolution_enable, output, 1 bit: CNN start pulse, active-low.
REQ-020 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-021 SHALL have port done, output, 1 bit: high from sequence completion until the next accepted start or reset.

Function
REQ-022 SHALL implement states IDLE, LOAD_FEAT, WR_FEAT, LOAD_BIAS, WR_BIAS, LOAD_FC, WR_FC and START_CNN, all registered.
REQ-023 SHALL drive in_ready = 1 only in the LOAD_* states; in all other states in_ready = 0 and in_data is ignored.
REQ-024 SHALL consume the stream in this order: 3x16 feature bytes, then 4 bias bytes, then 432 FC bytes, for 484 bytes in total.
REQ-025 SHALL pack each accepted byte as follows: the active shift register shifts left by 8 and in_data enters the low byte, so the first byte of a word ends in the MSBs.
REQ-026 SHALL, on acceptance of the last byte of a word (16th feature or FC byte, 4th bias byte), move the next cycle to the matching WR_* state.
REQ-027 SHALL, in each WR_* state, hold the matching WrEn low for exactly one cycle, with data and address stable in that cycle.
REQ-028 SHALL, in WR_FEAT, go to LOAD_FEAT with feature_writeAddr+1 if the slot is below 2; otherwise it goes to LOAD_BIAS.
REQ-029 SHALL, in WR_BIAS, go to LOAD_FC.
REQ-030 SHALL, in WR_FC, go to LOAD_FC with fullyconnected_writeAddr+1 if the address is below 26; otherwise it goes to START_CNN.
REQ-031 SHALL address the first feature write at slot 0 and the first FC write at address 0.
REQ-032 SHALL, in START_CNN, drive convolution_enable low for one cycle, then go to IDLE with done = 1.
REQ-033 SHALL keep data and address outputs unchanged outside their update points; the shift registers update only on accepted bytes.
REQ-034 SHALL, with in_valid held high, produce the convolution_enable low cycle 516 cycles after the first LOAD_FEAT cycle (counting that cycle as 1).
REQ-035 SHALL, when in_valid is low in a LOAD state, hold the state and stall with no byte loss or duplication.
REQ-036 SHALL ignore start while busy; a start in IDLE clears done.
REQ-037 SHALL keep the byte counter at 4 bits and wrap it to 0 at each word boundary.
REQ-038 SHALL never assert two WrEn strobes in the same cycle.

Reset
REQ-039 SHALL, while rst_loader = 0, hold: state IDLE; all WrEn = 1; convolution_enable = 1; in_ready, busy and done = 0; all data, address and counter registers = 0.
REQ-040 SHALL, when reset is asserted mid-sequence, abort immediately with no WrEn low pulse; a new start reloads from byte 0.

Verification
REQ-041 SHALL be verified for a full load: start, then 484 bytes (feature 0 = -53,43,...,26; biases 10,0,0,-8; FC values 0..431 mod 256) -> 3 feature writes at addr 0,1,2; bias word 0x0A0000F8; 27 FC writes at addr 0..26; one convolution_enable low pulse; done = 1.
REQ-042 SHALL be verified for back-pressure: random in_valid gaps -> the captured words are identical to the no-gap run, and the write count is unchanged.
REQ-043 SHALL be verified for latency: in_valid held high -> convolution_enable low in cycle 516, and each WrEn low exactly one cycle.
REQ-044 SHALL be verified for reset mid-FC: rst_loader low after FC word 10 -> immediate reset values with no extra WrEn; after a restart the sequence completes normally.
REQ-045 SHALL be verified for ignored inputs: start pulsed while busy, and in_valid with bytes while IDLE -> no state change and no bytes consumed.
